bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential double-dabble (shift-add-3) converter that sits directly downstream of the CPU's hex_display/GPIO output.
- Takes a binary word and produces DIGITS packed 4-bit BCD digits for the 7-segment decoders.
- One input bit is processed per cycle, with a valid/ready request and a done pulse.
- The last result is held stable between conversions, so the display never flickers.

Parameters:
- IN_W, 32, width of the binary input in bits (1..32).
- DIGITS, 10, number of BCD digits produced (1..10); results at or above 10^DIGITS are reduced modulo 10^DIGITS and flagged.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bin_in  in  IN_W  binary value to convert; sampled only on the accept edge.
- valid_in  in  1  request to convert bin_in.
- ready_out  out  1  high when the block can accept a request (IDLE state).
- bcd_out  out  4*DIGITS  result digits; digit i is bcd_out[4i+3:4i], and digit 0 is the least significant.
- overflow  out  1  high when the held result was truncated (value >= 10^DIGITS).
- done  out  1  one-cycle pulse when bcd_out/overflow update.
- blank  out  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, bcd_out=0, overflow=0, done=0, blank=0, shift and BCD work registers=0, bit counter=0. The reset takes effect immediately, including mid-conversion. The conversion in flight is discarded and no done is issued for it.
- States:
  - IDLE: ready_out=1.
  - SHIFT: ready_out=0.
- Accept: at a rising edge with state=IDLE and valid_in=1:
  - load shift reg <= bin_in;
  - clear the BCD work register and the overflow accumulator;
  - counter <= IN_W;
  - state <= SHIFT.
- Each SHIFT edge:
  - every work digit >= 5 gets +3 (combinational, on the current value);
  - then shift {work, shift_reg} left by 1;
  - the bit shifted out of the top digit is ORed into the overflow accumulator;
  - counter decrements.
- Completion: on the SHIFT edge where counter goes 1->0, the edge does the following:
  - performs the final adjust+shift;
  - writes bcd_out <= new work value and overflow <= accumulator (including this edge's carry);
  - sets done=1;
  - state <= IDLE.
- done is deasserted on the next edge.
- Latency: bcd_out is valid and done is high exactly IN_W cycles after the accept edge. Throughput is one conversion per IN_W+1 cycles minimum, because ready_out is high again on the cycle done is high.
- valid_in while in SHIFT: ignored, with no queueing. The upstream must hold or re-present the request.
- valid_in=1 in the same cycle done=1: the request is accepted on that edge, since state is IDLE, and done drops on that edge as normal.
- bcd_out and overflow change only on a completion edge. They are stable otherwise, even while a new conversion is in progress.
- Arithmetic: the work register is 4*DIGITS bits. Add-3 is applied per digit with no carry between digits. Result = bin_in mod 10^DIGITS, and every digit is always 0..9.
- IN_W=1: a single SHIFT cycle; the result is 0 or 1.

Optional Feature:
- Macro BIN2BCD_LZB_EN.
- Defined: on each completion edge, blank[i] <= 1 for every digit i above the most significant nonzero digit. blank[0] is never set, so a value of 0 shows a single "0". blank updates together with bcd_out and resets to 0.
- Undefined: the blank port is tied to 0 and no blanking logic is synthesized.

Test Plan:
- Reset, then valid_in=1 with bin_in=0 (IN_W=32, DIGITS=10) -> ready_out low for 32 cycles, done pulses once at cycle 32, bcd_out=0, overflow=0, blank=10'b1111111110 with LZB_EN.
- bin_in=32'hFFFFFFFF -> digits (MSB..LSB) 4,2,9,4,9,6,7,2,9,5, overflow=0, blank=0.
- DIGITS=5, bin_in=123456 -> bcd_out=20'h23456, overflow=1. A following conversion of 99999 -> bcd_out=20'h99999 and overflow=0.
- bin_in=1234 accepted; valid_in held high with bin_in=77 during SHIFT:
  - 77 is ignored until done;
  - the first result is 1234;
  - 77 is accepted on the done cycle and its result arrives IN_W cycles later;
  - bcd_out holds 1234 until then.
- rst_n pulsed low at cycle 10 of a 32-cycle conversion of 5000 -> outputs clear immediately and no done appears. A new request of 42 after release -> bcd_out=42, done at exactly 32 cycles.
- IN_W=17, DIGITS=6, bin_in=131071 (switch max) -> bcd_out=24'h131071, done 17 cycles after accept.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq: upstream drives bin_in/valid_in,
// the converter returns ready_out and the held BCD result.
interface bin2bcd_seq_if #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
);
    logic [IN_W-1:0]     bin_in;
    logic                valid_in;
    logic                ready_out;
    logic [4*DIGITS-1:0] bcd_out;
    logic                overflow;
    logic                done;
    logic [DIGITS-1:0]   blank;

    modport master (
        output bin_in, valid_in,
        input  ready_out, bcd_out, overflow, done, blank
    );

    modport slave (
        input  bin_in, valid_in,
        output ready_out, bcd_out, overflow, done, blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Define BIN2BCD_LZB_EN to build the leading-zero blank mask; otherwise blank is tied to 0.
module bin2bcd_seq #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int WORK_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(IN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     shift_q, shift_nxt;
    logic [WORK_W-1:0]   work_q, work_adj, work_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic                acc_q;
    logic                carry;
    logic [WORK_W-1:0]   bcd_q;
    logic                ovf_q;
    logic                done_q;
    logic                accept, step, last, ready;

    // Per-digit add-3 with no carry between digits; the top bit shifted out is a 10^DIGITS carry.
    always_comb begin
        work_adj = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5)
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        carry     = work_adj[WORK_W-1];
        work_nxt  = {work_adj[WORK_W-2:0], shift_q[IN_W-1]};
        shift_nxt = shift_q << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.valid_in) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            work_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                shift_q <= bus.bin_in;
                work_q  <= '0;
                acc_q   <= 1'b0;
                cnt_q   <= CNT_W'(IN_W);
            end else if (step) begin
                shift_q <= shift_nxt;
                work_q  <= work_nxt;
                acc_q   <= acc_q | carry;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            if (last) begin
                bcd_q <= work_nxt;
                ovf_q <= acc_q | carry;
            end
        end
    end

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] blank_nxt, blank_q;
    logic              seen_nz;

    // Walk down from the top digit; digit 0 is never blanked so zero still shows "0".
    always_comb begin
        blank_nxt = '0;
        seen_nz   = 1'b0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            seen_nz      = seen_nz | (work_nxt[4*i +: 4] != 4'd0);
            blank_nxt[i] = !seen_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    blank_q <= '0;
        else if (last) blank_q <= blank_nxt;
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    assign bus.ready_out = ready;
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations (32/10, 32/5, 17/6),
// directed vectors pushed on accept, checked by a negedge monitor on done.
module tb_bin2bcd_seq;
    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;

    logic [31:0] bin   [3];
    logic        valid [3];
    logic        ready [3];
    logic [39:0] bcd   [3];
    logic        ovf   [3];
    logic        done  [3];
    logic [9:0]  blank [3];

    int inw  [3] = '{32, 32, 17};
    int ndig [3] = '{10, 5, 6};

    exp_t        sb [3][$];
    logic [39:0] held_bcd [3] = '{40'd0, 40'd0, 40'd0};
    logic        held_ovf [3] = '{1'b0, 1'b0, 1'b0};

    bin2bcd_seq_if #(.IN_W(32), .DIGITS(10)) if_a ();
    bin2bcd_seq_if #(.IN_W(32), .DIGITS(5))  if_b ();
    bin2bcd_seq_if #(.IN_W(17), .DIGITS(6))  if_c ();

    bin2bcd_seq #(.IN_W(32), .DIGITS(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    bin2bcd_seq #(.IN_W(32), .DIGITS(5))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    bin2bcd_seq #(.IN_W(17), .DIGITS(6))  dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    assign if_a.bin_in   = bin[0];
    assign if_b.bin_in   = bin[1];
    assign if_c.bin_in   = bin[2][16:0];
    assign if_a.valid_in = valid[0];
    assign if_b.valid_in = valid[1];
    assign if_c.valid_in = valid[2];

    assign ready[0] = if_a.ready_out;
    assign ready[1] = if_b.ready_out;
    assign ready[2] = if_c.ready_out;
    assign bcd[0]   = 40'(if_a.bcd_out);
    assign bcd[1]   = 40'(if_b.bcd_out);
    assign bcd[2]   = 40'(if_c.bcd_out);
    assign ovf[0]   = if_a.overflow;
    assign ovf[1]   = if_b.overflow;
    assign ovf[2]   = if_c.overflow;
    assign done[0]  = if_a.done;
    assign done[1]  = if_b.done;
    assign done[2]  = if_c.done;
    assign blank[0] = 10'(if_a.blank);
    assign blank[1] = 10'(if_b.blank);
    assign blank[2] = 10'(if_c.blank);

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [9:0] exp_blank(input logic [39:0] b, input int nd);
        logic [9:0] r = '0;
`ifdef BIN2BCD_LZB_EN
        logic seen = 1'b0;
        for (int i = nd - 1; i >= 1; i--) begin
            seen = seen | (b[4*i +: 4] != 4'd0);
            r[i] = !seen;
        end
`else
        if (nd < 0) r = '1;
`endif
        return r;
    endfunction

    task automatic cmp(input int d, input string nm, input logic [39:0] act, input logic [39:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL dut%0d %s: actual=%h required=%h (t=%0t)", d, nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input int d, input string nm);
        compared++;
        mismatched++;
        $display("FAIL dut%0d %s: actual=timeout required=event (t=%0t)", d, nm, $time);
    endtask

    task automatic check(input int d);
        exp_t e;
        if (done[d]) begin
            if (sb[d].size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL dut%0d unexpected_done: actual bcd=%h required no done", d, bcd[d]);
            end else begin
                e = sb[d].pop_front();
                cmp(d, "bcd", bcd[d], e.bcd);
                cmp(d, "overflow", 40'(ovf[d]), 40'(e.ovf));
                cmp(d, "blank", 40'(blank[d]), 40'(e.blank));
                cmp(d, "latency_cycle", 40'(cycle), 40'(e.due));
                held_bcd[d] = e.bcd;
                held_ovf[d] = e.ovf;
            end
        end else begin
            cmp(d, "hold_bcd", bcd[d], held_bcd[d]);
            cmp(d, "hold_overflow", 40'(ovf[d]), 40'(held_ovf[d]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1)
            for (int d = 0; d < 3; d++) check(d);
    end

    // Called at posedge+1; holds valid until accepted, then queues the expected result.
    task automatic request(input int d, input logic [31:0] val, input logic [39:0] eb, input logic eo);
        exp_t e;
        int   n = 0;
        bin[d]   = val;
        valid[d] = 1'b1;
        while (!ready[d] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready[d]) begin
            fail_now(d, "ready_timeout");
            valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.bcd   = eb;
        e.ovf   = eo;
        e.blank = exp_blank(eb, ndig[d]);
        e.due   = cycle + inw[d];
        sb[d].push_back(e);
        valid[d] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) fail_now(0, "drain_timeout");
        #1;
    endtask

    task automatic check_reset_state(input int d);
        cmp(d, "rst_ready", 40'(ready[d]), 40'd1);
        cmp(d, "rst_bcd", bcd[d], 40'd0);
        cmp(d, "rst_overflow", 40'(ovf[d]), 40'd0);
        cmp(d, "rst_done", 40'(done[d]), 40'd0);
        cmp(d, "rst_blank", 40'(blank[d]), 40'd0);
    endtask

    initial begin
        int lo;
        int n;
        for (int d = 0; d < 3; d++) begin
            bin[d]   = '0;
            valid[d] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_reset_state(d);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero: ready low for the whole conversion, one done
        request(0, 32'd0, 40'h0000000000, 1'b0);
        lo = 0;
        n  = 0;
        while (!done[0] && n < 100) begin
            @(negedge clk);
            if (!ready[0]) lo++;
            n++;
        end
        cmp(0, "ready_low_cycles", 40'(lo), 40'd32);
        @(posedge clk);
        #1;

        request(0, 32'hFFFFFFFF, 40'h4294967295, 1'b0);
        request(0, 32'd9,        40'h0000000009, 1'b0);
        request(0, 32'd999999999, 40'h0999999999, 1'b0);
        // 77 is presented while 1234 is converting and must wait for the done cycle
        request(0, 32'd1234, 40'h0000001234, 1'b0);
        request(0, 32'd77,   40'h0000000077, 1'b0);

        request(1, 32'd123456, 40'h0000023456, 1'b1);
        request(1, 32'd99999,  40'h0000099999, 1'b0);
        request(1, 32'd100000, 40'h0000000000, 1'b1);

        request(2, 32'd131071, 40'h0000131071, 1'b0);
        request(2, 32'd0,      40'h0000000000, 1'b0);
        request(2, 32'd65536,  40'h0000065536, 1'b0);

        wait_drain();

        // Reset 10 cycles into a conversion: outputs clear at once, no done for 5000
        request(0, 32'd5000, 40'h0000005000, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sb[d].delete();
            held_bcd[d] = '0;
            held_ovf[d] = 1'b0;
        end
        #1;
        check_reset_state(0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        request(0, 32'd42, 40'h0000000042, 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
